axi_handshake_monitor: RTL and testbench
========================================

// Module: axi_handshake_monitor
// PURPOSE
//  Synthesisable run-time checker for NUM_CH valid/ready channels (AXI AR/R/AW/W/B at the cache ports).
//  It is the hardware counterpart of the cache SVA property library and flags three violation classes:
//  valid dropped before handshake, payload changed while stalled, and handshake timeout.
//  Errors produce pulses, sticky status, a saturating event count and a first-error capture,
//  so post-silicon debug can read them out.
// PARAMETERS
//  NUM_CH       4    number of monitored channels (>=1)
//  DATA_W       64   payload width per channel (>=1)
//  TIMEOUT_CYC  256  consecutive stalled cycles before timeout; 0 disables the timeout check
//  CNT_W        16   width of the saturating error counter
//  CH_W         max(1,$clog2(NUM_CH))  derived; width of the channel index
// PORTS
//  clk             in   1              clock; all logic on posedge
//  reset           in   1              synchronous reset, active-high
//  enable          in   1              1 = checks active; 0 = per-channel state cleared, no new events
//  clear           in   1              clears err_status, err_count and the first_err_* capture
//  valid           in   NUM_CH         per-channel valid
//  ready           in   NUM_CH         per-channel ready
//  payload         in   NUM_CH*DATA_W  per-channel payload; channel c at [c*DATA_W +: DATA_W]
//  err_pulse       out  NUM_CH*3       1-cycle event pulses; channel c bits [c*3 +: 3] = {timeout,data,drop}
//  err_status      out  NUM_CH*3       sticky OR of err_pulse; same layout
//  err_count       out  CNT_W          saturating count of error events
//  first_err_valid out  1              a first error has been captured since reset or clear
//  first_err_ch    out  CH_W           channel of the first error
//  first_err_code  out  2              1=drop 2=data 3=timeout (0 when not valid)
//  irq             out  1              registered |err_status
// BEHAVIOUR
//  Reset: every output and internal register is 0. Reset overrides enable and clear.
//  Per-channel FSM, all registered:
//   IDLE -> WAIT when valid&!ready. WAIT captures payload into pay_q and sets wait_cnt=1.
//   WAIT: valid&ready -> IDLE. !valid -> IDLE and raises a drop event. valid&!ready -> wait_cnt++.
//   WAIT -> TOUT when wait_cnt==TIMEOUT_CYC while still valid&!ready; this raises one timeout event.
//   TOUT: valid&ready -> IDLE. !valid -> IDLE and raises a drop event. No repeated timeout events.
//   A handshake in the same cycle valid first rises (valid&ready in IDLE) stays in IDLE with no event.
//  Data check: in WAIT/TOUT with valid=1, payload!=pay_q raises a data event.
//   pay_q is not updated, so every differing cycle raises a data event.
//  Event latency: an offending input sampled at edge t gives err_pulse high for exactly the cycle after edge t.
//   err_status, err_count and first_err_* update on that same edge. irq follows one cycle later.
//  The drop and data checks are mutually exclusive per cycle. Timeout can coincide with data on one channel.
//  err_count adds the popcount of all new events in the cycle and saturates at 2^CNT_W-1. It never wraps.
//  First-error capture: taken only when first_err_valid==0.
//   Among simultaneous events, the lowest channel index wins; within a channel, drop > data > timeout.
//  clear together with a new event in the same cycle: clear applies first, then the new event is recorded.
//   Status and capture hold that event; the count equals the popcount of that cycle.
//  enable=0: FSMs forced to IDLE, wait_cnt=0, no events. err_status, err_count and capture are held.
//   A channel already stalled when enable rises starts in IDLE. It enters WAIT on the next valid&!ready
//   cycle, so no false drop or data event is raised.
//  wait_cnt is sized to hold TIMEOUT_CYC. With TIMEOUT_CYC=0 the TOUT state is unreachable.
//  Reset mid-stall: the channel returns to IDLE and no event is raised for the aborted transfer.
// TESTING
//  1 ch0 valid=1 ready=0 for 3 cycles, then valid=0 -> err_pulse[0]=1 one cycle later, err_count=1,
//    first_err_ch=0, first_err_code=1, irq=1 on the next cycle.
//  2 ch2 stalled, payload changes 0xA5 -> 0x5A for 2 cycles -> two data pulses on bit[7], err_count=2,
//    err_status[7] remains set.
//  3 TIMEOUT_CYC=4, ch1 stalled 10 cycles then ready -> exactly one timeout pulse (bit[5]) after the
//    4th stalled cycle. The handshake returns ch1 to IDLE with no drop event.
//  4 ch3 drop and ch1 data in the same cycle -> err_count+=2, first_err_ch=1, first_err_code=2.
//  5 CNT_W=2, inject 5 drop events -> err_count saturates at 3. Then clear in the same cycle as a new
//    drop -> err_count=1, first_err_valid=1.
//  6 enable=0 while ch0 stalled with payload changing, then enable=1 with ch0 still stalled ->
//    no events. The first event is only possible after WAIT is re-entered.

Source files
------------

// File: rtl/axi_handshake_monitor.sv
// axi_handshake_monitor
// Run-time checker for NUM_CH valid/ready channels. Flags three violations
// per channel: valid dropped before handshake, payload changed while stalled,
// and handshake timeout. Reports per-event pulses, sticky status, a saturating
// event count, a first-error capture and an interrupt line.
module axi_handshake_monitor #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 16,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        valid,
    input  logic [NUM_CH-1:0]        ready,
    input  logic [NUM_CH*DATA_W-1:0] payload,
    output logic [NUM_CH*3-1:0]      err_pulse,
    output logic [NUM_CH*3-1:0]      err_status,
    output logic [CNT_W-1:0]         err_count,
    output logic                     first_err_valid,
    output logic [CH_W-1:0]          first_err_ch,
    output logic [1:0]               first_err_code,
    output logic                     irq
);

    localparam int EV_W  = NUM_CH * 3;
    localparam int WC_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int POP_W = $clog2(EV_W + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [WC_W-1:0]  TO_VAL  = WC_W'(TIMEOUT_CYC);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TOUT = 2'd2
    } state_t;

    // New events of this cycle, layout {timeout,data,drop} per channel
    logic [EV_W-1:0] ev_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t            state_q, state_d;
            logic [WC_W-1:0]   cnt_q, cnt_d;
            logic [DATA_W-1:0] pay_q, pay_d;
            logic              ev_drop, ev_data, ev_tout;
            logic [DATA_W-1:0] pay_in;

            assign pay_in = payload[gi*DATA_W +: DATA_W];
            assign ev_vec[gi*3 +: 3] = {ev_tout, ev_data, ev_drop};

            // Per-channel handshake tracking and violation detection
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                pay_d   = pay_q;
                ev_drop = 1'b0;
                ev_data = 1'b0;
                ev_tout = 1'b0;
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (valid[gi] && !ready[gi]) begin
                                state_d = ST_WAIT;
                                pay_d   = pay_in;
                                cnt_d   = WC_W'(1);
                            end
                        end
                        ST_WAIT, ST_TOUT: begin
                            if (!valid[gi]) begin
                                ev_drop = 1'b1;
                                state_d = ST_IDLE;
                                cnt_d   = '0;
                            end else begin
                                ev_data = (pay_in != pay_q);
                                if (ready[gi]) begin
                                    state_d = ST_IDLE;
                                    cnt_d   = '0;
                                end else if (state_q == ST_WAIT && TIMEOUT_CYC != 0) begin
                                    // Counter stops at the limit; TOUT never re-fires
                                    if (cnt_q == TO_VAL) begin
                                        state_d = ST_TOUT;
                                        ev_tout = 1'b1;
                                    end else begin
                                        cnt_d = cnt_q + WC_W'(1);
                                    end
                                end
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end

            // Per-channel state registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    pay_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    pay_q   <= pay_d;
                end
            end
        end
    endgenerate

    logic [EV_W-1:0]  pulse_q, pulse_d;
    logic [EV_W-1:0]  status_q, status_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fv_q, fv_d;
    logic [CH_W-1:0]  fch_q, fch_d;
    logic [1:0]       fcode_q, fcode_d;
    logic             irq_q, irq_d;
    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] sum;

    // Aggregate status: clear acts before this cycle's events are folded in
    always_comb begin
        pop = '0;
        for (int i = 0; i < EV_W; i++) begin
            pop = pop + POP_W'(ev_vec[i]);
        end
        pulse_d  = ev_vec;
        status_d = (clear ? '0 : status_q) | ev_vec;
        sum      = SUM_W'(clear ? '0 : count_q) + SUM_W'(pop);
        count_d  = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
        fv_d     = clear ? 1'b0 : fv_q;
        fch_d    = clear ? '0 : fch_q;
        fcode_d  = clear ? 2'd0 : fcode_q;
        if (!fv_d) begin
            // Lowest channel wins; within a channel drop > data > timeout
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (ev_vec[c*3 +: 3] != 3'b000) begin
                    fv_d    = 1'b1;
                    fch_d   = CH_W'(c);
                    fcode_d = ev_vec[c*3] ? 2'd1 : (ev_vec[c*3+1] ? 2'd2 : 2'd3);
                end
            end
        end
        irq_d = |status_q;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q  <= '0;
            status_q <= '0;
            count_q  <= '0;
            fv_q     <= 1'b0;
            fch_q    <= '0;
            fcode_q  <= 2'd0;
            irq_q    <= 1'b0;
        end else begin
            pulse_q  <= pulse_d;
            status_q <= status_d;
            count_q  <= count_d;
            fv_q     <= fv_d;
            fch_q    <= fch_d;
            fcode_q  <= fcode_d;
            irq_q    <= irq_d;
        end
    end

    assign err_pulse       = pulse_q;
    assign err_status      = status_q;
    assign err_count       = count_q;
    assign first_err_valid = fv_q;
    assign first_err_ch    = fch_q;
    assign first_err_code  = fcode_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_axi_handshake_monitor.sv
// Bench for axi_handshake_monitor: directed scenarios plus a randomized run
// checked cycle by cycle against a transaction-level reference model.
module tb_axi_handshake_monitor;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int TO  = 4;
    localparam int CW  = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset, enable, clear;
    logic [NCH-1:0]   valid, ready;
    logic [NCH*DW-1:0] payload;
    logic [NCH*3-1:0] err_pulse, err_status;
    logic [CW-1:0]    err_count;
    logic             first_err_valid;
    logic [1:0]       first_err_ch;
    logic [1:0]       first_err_code;
    logic             irq;

    int n_checks = 0;
    int n_fail   = 0;

    axi_handshake_monitor #(
        .NUM_CH(NCH), .DATA_W(DW), .TIMEOUT_CYC(TO), .CNT_W(CW), .CH_W(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .valid(valid), .ready(ready), .payload(payload),
        .err_pulse(err_pulse), .err_status(err_status), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_ch(first_err_ch),
        .first_err_code(first_err_code), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: a channel has an outstanding transfer once it stalls;
    // stalls counts stalled cycles since the transfer was first seen.
    bit          m_pend  [NCH];
    int          m_stalls[NCH];
    logic [DW-1:0] m_held[NCH];
    logic [NCH*3-1:0] e_pulse, e_status;
    int          e_count;
    logic        e_fv;
    logic [1:0]  e_fch, e_fcode;
    logic        e_irq;

    task automatic model_step();
        logic [NCH*3-1:0] ev;
        logic [DW-1:0] p;
        logic irq_new;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = 0; m_stalls[c] = 0; m_held[c] = '0;
            end
            e_pulse = '0; e_status = '0; e_count = 0;
            e_fv = 0; e_fch = 0; e_fcode = 0; e_irq = 0;
            return;
        end
        ev = '0;
        for (int c = 0; c < NCH; c++) begin
            p = payload[c*DW +: DW];
            if (!enable) begin
                m_pend[c] = 0;
                m_stalls[c] = 0;
            end else if (!m_pend[c]) begin
                if (valid[c] && !ready[c]) begin
                    m_pend[c] = 1; m_held[c] = p; m_stalls[c] = 1;
                end
            end else begin
                if (!valid[c]) ev[c*3] = 1'b1;
                else begin
                    if (p != m_held[c]) ev[c*3+1] = 1'b1;
                    if (!ready[c]) begin
                        if (m_stalls[c] == TO) ev[c*3+2] = 1'b1;
                        m_stalls[c]++;
                    end
                end
                if (!valid[c] || ready[c]) m_pend[c] = 0;
            end
        end
        irq_new = |e_status;
        if (clear) begin
            e_status = '0; e_count = 0; e_fv = 0; e_fch = 0; e_fcode = 0;
        end
        e_status = e_status | ev;
        e_count  = e_count + $countones(ev);
        if (e_count > CMAX) e_count = CMAX;
        for (int c = 0; c < NCH; c++) begin
            if (!e_fv && ev[c*3 +: 3] != 3'b000) begin
                e_fv    = 1'b1;
                e_fch   = 2'(c);
                e_fcode = ev[c*3] ? 2'd1 : (ev[c*3+1] ? 2'd2 : 2'd3);
            end
        end
        e_pulse = ev;
        e_irq   = irq_new;
    endtask

    // One clock: model consumes the sampled inputs, outputs settle by #1
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1; clear = 0; valid = '0; ready = '0; payload = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; clear = 0;
        valid = '1; ready = '0; payload = 32'hDEADBEEF;
        tick(); tick();
        n_checks++;
        if ({err_pulse, err_status, err_count, first_err_valid, first_err_ch,
             first_err_code, irq} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%h required 0",
                {err_pulse, err_status, err_count, first_err_valid, first_err_ch,
                 first_err_code, irq});
        end
        reset = 0;
        idle_inputs();
        tick();
        $display("test_reset done");
    endtask

    task automatic test_drop();
        do_reset();
        valid[0] = 1; payload[7:0] = 8'h3C;
        repeat (3) tick();
        valid[0] = 0;
        tick();
        n_checks++;
        if (err_pulse !== 12'h001 || err_count !== 3'd1 || first_err_valid !== 1'b1 ||
            first_err_ch !== 2'd0 || first_err_code !== 2'd1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_event: pulse=%h cnt=%0d fv=%b ch=%0d code=%0d irq=%b required 001 1 1 0 1 0",
                err_pulse, err_count, first_err_valid, first_err_ch, first_err_code, irq);
        end
        tick();
        n_checks++;
        if (irq !== 1'b1 || err_pulse !== 12'h000 || err_status !== 12'h001) begin
            n_fail++;
            $display("FAIL drop_irq: irq=%b pulse=%h status=%h required 1 000 001",
                irq, err_pulse, err_status);
        end
        $display("test_drop done");
    endtask

    task automatic test_data();
        do_reset();
        valid[2] = 1; payload[23:16] = 8'hA5;
        tick();
        payload[23:16] = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (err_pulse !== 12'h080 || err_count !== 3'(i + 1)) begin
                n_fail++;
                $display("FAIL data_pulse%0d: pulse=%h cnt=%0d required 080 %0d",
                    i, err_pulse, err_count, i + 1);
            end
        end
        payload[23:16] = 8'hA5; ready[2] = 1;
        tick();
        n_checks++;
        if (err_pulse !== 12'h000 || err_status[7] !== 1'b1 || err_count !== 3'd2 ||
            first_err_code !== 2'd2 || first_err_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL data_hold: pulse=%h status=%h cnt=%0d ch=%0d code=%0d required 000 bit7 2 2 2",
                err_pulse, err_status, err_count, first_err_ch, first_err_code);
        end
        $display("test_data done");
    endtask

    task automatic test_timeout();
        int npulse;
        npulse = 0;
        do_reset();
        valid[1] = 1; payload[15:8] = 8'h11;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (err_pulse[5]) npulse++;
            n_checks++;
            if (err_pulse !== ((i == TO) ? 12'h020 : 12'h000)) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: pulse=%h required %h",
                    i, err_pulse, (i == TO) ? 12'h020 : 12'h000);
            end
        end
        ready[1] = 1;
        tick();
        n_checks++;
        if (npulse != 1 || err_pulse !== 12'h000 || err_count !== 3'd1 ||
            first_err_code !== 2'd3 || err_status !== 12'h020) begin
            n_fail++;
            $display("FAIL timeout_end: npulse=%0d pulse=%h cnt=%0d code=%0d status=%h required 1 000 1 3 020",
                npulse, err_pulse, err_count, first_err_code, err_status);
        end
        $display("test_timeout done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        valid[1] = 1; valid[3] = 1;
        payload[15:8] = 8'h77; payload[31:24] = 8'h99;
        tick();
        valid[3] = 0; payload[15:8] = 8'h78;
        tick();
        n_checks++;
        if (err_pulse !== 12'h210 || err_count !== 3'd2 || first_err_ch !== 2'd1 ||
            first_err_code !== 2'd2) begin
            n_fail++;
            $display("FAIL simultaneous: pulse=%h cnt=%0d ch=%0d code=%0d required 210 2 1 2",
                err_pulse, err_count, first_err_ch, first_err_code);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_saturate();
        do_reset();
        payload[7:0] = 8'h42;
        for (int k = 1; k <= 9; k++) begin
            valid[0] = 1; tick();
            valid[0] = 0; tick();
            n_checks++;
            if (err_count !== 3'((k > CMAX) ? CMAX : k)) begin
                n_fail++;
                $display("FAIL saturate%0d: cnt=%0d required %0d",
                    k, err_count, (k > CMAX) ? CMAX : k);
            end
        end
        valid[0] = 1; tick();
        valid[0] = 0; clear = 1; tick();
        clear = 0;
        n_checks++;
        if (err_count !== 3'd1 || first_err_valid !== 1'b1 || first_err_ch !== 2'd0 ||
            first_err_code !== 2'd1 || err_status !== 12'h001) begin
            n_fail++;
            $display("FAIL clear_with_event: cnt=%0d fv=%b ch=%0d code=%0d status=%h required 1 1 0 1 001",
                err_count, first_err_valid, first_err_ch, first_err_code, err_status);
        end
        $display("test_saturate done");
    endtask

    task automatic test_enable();
        do_reset();
        valid[0] = 1; payload[7:0] = 8'h10;
        tick();
        enable = 0;
        for (int i = 0; i < 4; i++) begin
            payload[7:0] = 8'(8'h20 + i);
            tick();
            n_checks++;
            if (err_pulse !== 12'h000) begin
                n_fail++;
                $display("FAIL disabled%0d: pulse=%h required 000", i, err_pulse);
            end
        end
        enable = 1; payload[7:0] = 8'h30;
        tick();
        n_checks++;
        if (err_pulse !== 12'h000 || err_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reenable: pulse=%h cnt=%0d required 000 0", err_pulse, err_count);
        end
        payload[7:0] = 8'h31;
        tick();
        n_checks++;
        if (err_pulse !== 12'h002 || err_count !== 3'd1) begin
            n_fail++;
            $display("FAIL rewait_data: pulse=%h cnt=%0d required 002 1", err_pulse, err_count);
        end
        $display("test_enable done");
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset  = ($urandom_range(0, 255) == 0);
            enable = ($urandom_range(0, 15) != 0);
            clear  = ($urandom_range(0, 31) == 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) valid[c] = ~valid[c];
                ready[c] = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 7) == 0) payload[c*DW +: DW] = 8'($urandom);
            end
            tick();
            n_checks++;
            if ({err_pulse, err_status, err_count, first_err_valid, first_err_ch,
                 first_err_code, irq} !==
                {e_pulse, e_status, 3'(e_count), e_fv, e_fch, e_fcode, e_irq}) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cyc%0d: pulse=%h status=%h cnt=%0d fv=%b ch=%0d code=%0d irq=%b required %h %h %0d %b %0d %0d %b",
                        cyc, err_pulse, err_status, err_count, first_err_valid, first_err_ch,
                        first_err_code, irq, e_pulse, e_status, e_count, e_fv, e_fch,
                        e_fcode, e_irq);
            end
        end
        reset = 0;
        $display("test_random done mismatches=%0d", bad);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_drop();
        test_data();
        test_timeout();
        test_simultaneous();
        test_saturate();
        test_enable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
